// File: rtl/safety_mem_port_arbiter.sv
// safety_mem_port_arbiter: shares one OBI memory port between a data requester
// and a shadow requester. It tracks in-flight transactions in a small ID FIFO so
// each response is steered back to the port that issued it.
// Optional feature: define SAFETY_ARB_RR_EN for round-robin arbitration.
// Without it the data port has fixed priority.
module safety_mem_port_arbiter #(
  parameter int NumOutstanding = 2,
  parameter int ErrBits        = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  // data requester
  input  logic                              d_req_i,
  input  logic                              d_we_i,
  input  logic [3:0]                        d_be_i,
  input  logic [31:0]                       d_addr_i,
  input  logic [31:0]                       d_wdata_i,
  output logic                              d_gnt_o,
  output logic                              d_rvalid_o,
  output logic [31:0]                       d_rdata_o,
  output logic [ErrBits-1:0]                d_err_o,
  // shadow requester
  input  logic                              s_req_i,
  input  logic                              s_we_i,
  input  logic [3:0]                        s_be_i,
  input  logic [31:0]                       s_addr_i,
  input  logic [31:0]                       s_wdata_i,
  output logic                              s_gnt_o,
  output logic                              s_rvalid_o,
  output logic [31:0]                       s_rdata_o,
  output logic [ErrBits-1:0]                s_err_o,
  // shared memory port
  output logic                              mem_req_o,
  output logic                              mem_we_o,
  output logic [3:0]                        mem_be_o,
  output logic [31:0]                       mem_addr_o,
  output logic [31:0]                       mem_wdata_o,
  input  logic                              mem_gnt_i,
  input  logic                              mem_rvalid_i,
  input  logic [31:0]                       mem_rdata_i,
  input  logic [ErrBits-1:0]                mem_err_i,
  // status
  output logic [$clog2(NumOutstanding+1)-1:0] outstanding_o,
  output logic                              unexp_rsp_o
);

  localparam int CntW = $clog2(NumOutstanding + 1);
  localparam int PtrW = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;

  // ID FIFO storage: one bit per entry, 0 = data, 1 = shadow
  logic [NumOutstanding-1:0] id_mem_q, id_mem_d;
  logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]           count_q, count_d;
  logic                      lock_q, lock_d;
  logic                      lock_id_q, lock_id_d;
  logic                      unexp_q, unexp_d;
`ifdef SAFETY_ARB_RR_EN
  logic                      rr_ptr_q, rr_ptr_d;
`endif

  logic winner;
  logic rsp_match;
  logic full;
  logic push;
  logic pop;
  logic head_id;

  // Pick the port that drives the memory request; a stalled request keeps its owner
  always_comb begin
    winner = 1'b0;
    if (lock_q) begin
      winner = lock_id_q;
    end else if (d_req_i && s_req_i) begin
`ifdef SAFETY_ARB_RR_EN
      winner = rr_ptr_q;
`else
      winner = 1'b0;
`endif
    end else if (s_req_i) begin
      winner = 1'b1;
    end
  end

  // Request gating, handshake detection and response steering
  always_comb begin
    rsp_match   = mem_rvalid_i && (count_q != '0);
    // a response retiring this cycle frees a slot for a same-cycle request
    full        = (count_q == CntW'(NumOutstanding)) && !rsp_match;
    mem_req_o   = (d_req_i || s_req_i) && !full && !rst_i;
    push        = mem_req_o && mem_gnt_i;
    pop         = rsp_match && !rst_i;
    head_id     = id_mem_q[rd_ptr_q];

    d_gnt_o     = push && !winner;
    s_gnt_o     = push && winner;

    mem_we_o    = winner ? s_we_i    : d_we_i;
    mem_be_o    = winner ? s_be_i    : d_be_i;
    mem_addr_o  = winner ? s_addr_i  : d_addr_i;
    mem_wdata_o = winner ? s_wdata_i : d_wdata_i;

    d_rvalid_o  = pop && !head_id;
    s_rvalid_o  = pop && head_id;
    d_rdata_o   = mem_rdata_i;
    s_rdata_o   = mem_rdata_i;
    d_err_o     = mem_err_i;
    s_err_o     = mem_err_i;

    outstanding_o = count_q;
    unexp_rsp_o   = unexp_q;
  end

  // Next-state for FIFO pointers, occupancy, lock, sticky error and priority
  always_comb begin
    id_mem_d  = id_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    lock_d    = mem_req_o && !mem_gnt_i;
    lock_id_d = winner;
    unexp_d   = unexp_q || (mem_rvalid_i && (count_q == '0));
`ifdef SAFETY_ARB_RR_EN
    rr_ptr_d  = push ? !winner : rr_ptr_q;
`endif

    if (push) begin
      id_mem_d[wr_ptr_q] = winner;
      wr_ptr_d = (wr_ptr_q == PtrW'(NumOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(NumOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_mem_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      unexp_q   <= 1'b0;
`ifdef SAFETY_ARB_RR_EN
      rr_ptr_q  <= 1'b0;
`endif
    end else begin
      id_mem_q  <= id_mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      unexp_q   <= unexp_d;
`ifdef SAFETY_ARB_RR_EN
      rr_ptr_q  <= rr_ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_safety_mem_port_arbiter.sv
// Directed bench for safety_mem_port_arbiter with a response scoreboard:
// the issuing port ID is queued at each expected handshake and popped when a
// memory response is driven.
module tb_safety_mem_port_arbiter;

  localparam int NumOutstanding = 2;
  localparam int ErrBits        = 2;
  localparam int CntW           = $clog2(NumOutstanding + 1);

  localparam logic [31:0] D_ADDR  = 32'h0000_0100;
  localparam logic [31:0] S_ADDR  = 32'h0000_0200;
  localparam logic [31:0] D_WDATA = 32'hD0D0_0001;
  localparam logic [31:0] S_WDATA = 32'h5A5A_0002;
  localparam logic [3:0]  D_BE    = 4'hF;
  localparam logic [3:0]  S_BE    = 4'h3;

  logic clk_i, rst_i;
  logic d_req_i, d_we_i, s_req_i, s_we_i;
  logic [3:0] d_be_i, s_be_i;
  logic [31:0] d_addr_i, d_wdata_i, s_addr_i, s_wdata_i;
  logic d_gnt_o, d_rvalid_o, s_gnt_o, s_rvalid_o;
  logic [31:0] d_rdata_o, s_rdata_o;
  logic [ErrBits-1:0] d_err_o, s_err_o;
  logic mem_req_o, mem_we_o;
  logic [3:0] mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [ErrBits-1:0] mem_err_i;
  logic [CntW-1:0] outstanding_o;
  logic unexp_rsp_o;

  int n_cmp = 0;
  int n_mis = 0;
  int exp_q[$];
  bit unexp_m = 1'b0;
  bit rr_m    = 1'b0;

  safety_mem_port_arbiter #(
    .NumOutstanding(NumOutstanding),
    .ErrBits(ErrBits)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .s_req_i(s_req_i), .s_we_i(s_we_i), .s_be_i(s_be_i), .s_addr_i(s_addr_i),
    .s_wdata_i(s_wdata_i), .s_gnt_o(s_gnt_o), .s_rvalid_o(s_rvalid_o),
    .s_rdata_o(s_rdata_o), .s_err_o(s_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .outstanding_o(outstanding_o), .unexp_rsp_o(unexp_rsp_o)
  );

  // free-running clock, 10 time units per period
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic dreq, input logic sreq, input logic gnt,
                               input logic rvalid, input logic [31:0] rdata);
    d_req_i      = dreq;
    s_req_i      = sreq;
    mem_gnt_i    = gnt;
    mem_rvalid_i = rvalid;
    mem_rdata_i  = rdata;
    mem_err_i    = rdata[ErrBits-1:0];
    #2;
  endtask

  function automatic int bothWinner();
`ifdef SAFETY_ARB_RR_EN
    return int'(rr_m);
`else
    return 0;
`endif
  endfunction

  task automatic expectIssue(input string tag, input int id, input bit granted);
    checkOutput({tag, ".req"},   32'(mem_req_o), 32'd1);
    checkOutput({tag, ".addr"},  mem_addr_o, (id == 1) ? S_ADDR : D_ADDR);
    checkOutput({tag, ".wdata"}, mem_wdata_o, (id == 1) ? S_WDATA : D_WDATA);
    checkOutput({tag, ".be"},    32'(mem_be_o), 32'((id == 1) ? S_BE : D_BE));
    checkOutput({tag, ".we"},    32'(mem_we_o), 32'((id == 1) ? s_we_i : d_we_i));
    checkOutput({tag, ".dgnt"},  32'(d_gnt_o), 32'(granted && (id == 0)));
    checkOutput({tag, ".sgnt"},  32'(s_gnt_o), 32'(granted && (id == 1)));
    if (granted) begin
      exp_q.push_back(id);
      rr_m = (id == 0);
    end
  endtask

  task automatic expectIdle(input string tag);
    checkOutput({tag, ".req"},  32'(mem_req_o), 32'd0);
    checkOutput({tag, ".dgnt"}, 32'(d_gnt_o), 32'd0);
    checkOutput({tag, ".sgnt"}, 32'(s_gnt_o), 32'd0);
  endtask

  task automatic expectResponse(input string tag);
    int  id;
    bit  exp_d, exp_s;
    exp_d = 1'b0;
    exp_s = 1'b0;
    if (mem_rvalid_i) begin
      if (exp_q.size() > 0) begin
        id    = exp_q.pop_front();
        exp_d = (id == 0);
        exp_s = (id == 1);
      end else begin
        unexp_m = 1'b1;
      end
      checkOutput({tag, ".drdata"}, d_rdata_o, mem_rdata_i);
      checkOutput({tag, ".srdata"}, s_rdata_o, mem_rdata_i);
      checkOutput({tag, ".derr"},   32'(d_err_o), 32'(mem_err_i));
      checkOutput({tag, ".serr"},   32'(s_err_o), 32'(mem_err_i));
    end
    checkOutput({tag, ".drvalid"}, 32'(d_rvalid_o), 32'(exp_d));
    checkOutput({tag, ".srvalid"}, 32'(s_rvalid_o), 32'(exp_s));
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, ".outst"}, 32'(outstanding_o), 32'(exp_q.size()));
    checkOutput({tag, ".unexp"}, 32'(unexp_rsp_o), 32'(unexp_m));
  endtask

  task automatic doReset(input string tag);
    rst_i = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    exp_q.delete();
    unexp_m = 1'b0;
    rr_m    = 1'b0;
    checkState(tag);
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    d_we_i = 1'b1; d_be_i = D_BE; d_addr_i = D_ADDR; d_wdata_i = D_WDATA;
    s_we_i = 1'b0; s_be_i = S_BE; s_addr_i = S_ADDR; s_wdata_i = S_WDATA;

    // reset: every handshake output held low even with all inputs active
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h1234);
    checkOutput("rst.req",     32'(mem_req_o),  32'd0);
    checkOutput("rst.dgnt",    32'(d_gnt_o),    32'd0);
    checkOutput("rst.sgnt",    32'(s_gnt_o),    32'd0);
    checkOutput("rst.drvalid", 32'(d_rvalid_o), 32'd0);
    checkOutput("rst.srvalid", 32'(s_rvalid_o), 32'd0);
    tick();
    tick();
    checkState("rst");
    rst_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkState("idle");

    // single data write to 0x100 then its response
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    expectIssue("w100", 0, 1'b1);
    tick();
    checkState("w100.post");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFE_0001);
    expectResponse("w100.rsp");
    expectIdle("w100.rsp");
    tick();
    checkState("w100.rsp.post");

    // both ports request continuously, responses one cycle behind grants
    d_we_i = 1'b0;
    s_we_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, (i > 0), 32'hB000_0000 + 32'(i));
      expectResponse($sformatf("both%0d", i));
      expectIssue($sformatf("both%0d", i), bothWinner(), 1'b1);
      tick();
      checkState($sformatf("both%0d.post", i));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hB000_0004);
    expectResponse("both.last");
    tick();
    checkState("both.last.post");

    // fill the FIFO, then show a same-cycle response frees the slot
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      expectIssue($sformatf("fill%0d", i), 0, 1'b1);
      tick();
    end
    checkState("fill.post");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    expectIdle("full");
    tick();
    checkState("full.post");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'hF000_0010 + 32'(i));
      expectResponse($sformatf("swap%0d", i));
      expectIssue($sformatf("swap%0d", i), 0, 1'b1);
      tick();
      checkState($sformatf("swap%0d.post", i));
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hF000_0020 + 32'(i));
      expectResponse($sformatf("drain%0d", i));
      tick();
      checkState($sformatf("drain%0d.post", i));
    end

    // stalled shadow request keeps the port while data also requests
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    expectIssue("stall0", 1, 1'b0);
    tick();
    for (int i = 1; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      expectIssue($sformatf("stall%0d", i), 1, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    expectIssue("stall.gnt", 1, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    expectIssue("stall.data", 0, 1'b1);
    tick();
    checkState("stall.post");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hA000_0000 + 32'(i));
      expectResponse($sformatf("stall.rsp%0d", i));
      tick();
      checkState($sformatf("stall.rsp%0d.post", i));
    end

    // unexpected response is dropped and sticks until reset
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_0003);
    expectResponse("unexp");
    tick();
    checkState("unexp.post");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkState("unexp.hold");
    doReset("unexp.rst");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkState("unexp.clr");

    // reset with two in flight discards them; a late response is unexpected
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      expectIssue($sformatf("inflt%0d", i), 0, 1'b1);
      tick();
    end
    checkState("inflt.post");
    doReset("inflt.rst");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hBEEF_0001);
    expectResponse("late");
    tick();
    checkState("late.post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/safety_mem_port_arbiter.md
SAFETY_MEM_PORT_ARBITER -- requirements
Module: safety_mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter NumOutstanding, default 2: the response-FIFO depth and the maximum number of in-flight memory transactions (minimum 1).
REQ-002 The block SHALL have parameter ErrBits, default 2: the width of the bus-error field per response.
REQ-003 The block SHALL have port clk_i  in  1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i  in  1: reset, synchronous and active-high.
REQ-005 The block SHALL have ports d_req_i, d_we_i  in  1 each: data-requester request and write enable.
REQ-006 The block SHALL have ports d_be_i  in  4, d_addr_i  in  32, d_wdata_i  in  32: data-requester byte enables, address and write data.
REQ-007 The block SHALL have ports d_gnt_o, d_rvalid_o  out  1 each, d_rdata_o  out  32, d_err_o  out  ErrBits: data-requester grant and response.
REQ-008 The block SHALL have a shadow-requester port set s_* identical in names, directions and widths to REQ-005..REQ-007.
REQ-009 The block SHALL have ports mem_req_o, mem_we_o  out  1 each, mem_be_o  out  4, mem_addr_o  out  32, mem_wdata_o  out  32: the shared OBI memory request.
REQ-010 The block SHALL have ports mem_gnt_i, mem_rvalid_i  in  1 each, mem_rdata_i  in  32, mem_err_i  in  ErrBits: the shared OBI memory grant and response.
REQ-011 The block SHALL have port outstanding_o  out  $clog2(NumOutstanding+1): the current number of in-flight transactions.
REQ-012 The block SHALL have port unexp_rsp_o  out  1: sticky flag set by a response with no transaction in flight.

Function
REQ-013 mem_req_o SHALL be (d_req_i | s_req_i) & ~full; while full, mem_req_o, d_gnt_o and s_gnt_o SHALL be 0.
REQ-014 The winner SHALL be selected combinationally; mem_we/be/addr/wdata SHALL be driven from the winner's inputs.
REQ-015 The winner's gnt_o SHALL equal mem_gnt_i; the loser's gnt_o SHALL be 0.
REQ-016 Once mem_req_o is high without mem_gnt_i, the winner SHALL be locked until the handshake completes, even if the other port raises req.
REQ-017 On each handshake (mem_req_o & mem_gnt_i), the winner ID (0 = data, 1 = shadow) SHALL be pushed into the response FIFO.
REQ-018 On mem_rvalid_i with the FIFO non-empty, the head ID SHALL be popped; the matching rvalid_o SHALL pulse in the same cycle; rdata_o and err_o SHALL be broadcast to both ports.
REQ-019 The non-selected rvalid_o SHALL be 0; responses SHALL have zero added latency.
REQ-020 On mem_rvalid_i with the FIFO empty, the response SHALL be dropped (no rvalid_o) and unexp_rsp_o SHALL set and stay set until reset.
REQ-021 A push and a pop in the same cycle SHALL leave the occupancy unchanged; read/write pointers SHALL wrap modulo NumOutstanding.
REQ-022 outstanding_o SHALL be the registered occupancy (pushes minus pops).

Reset
REQ-023 While rst_i is high: FIFO empty, outstanding_o = 0, unexp_rsp_o = 0, lock cleared, round-robin pointer = data.
REQ-024 While rst_i is high, mem_req_o, d_gnt_o, s_gnt_o, d_rvalid_o and s_rvalid_o SHALL be 0.
REQ-025 Reset asserted mid-transaction SHALL discard all in-flight IDs; responses arriving after reset SHALL be treated as unexpected.

Configuration
REQ-026 With SAFETY_ARB_RR_EN defined: round-robin arbitration; the priority pointer toggles to the other port after each handshake, so on simultaneous requests the port not most recently granted wins.
REQ-027 Without SAFETY_ARB_RR_EN: fixed priority, data port always wins simultaneous requests; the pointer register is absent.

Verification
REQ-028 Data write to addr 0x100, mem_gnt_i = 1 -> d_gnt_o = 1 in the same cycle; one cycle later mem_rvalid_i -> d_rvalid_o = 1, s_rvalid_o = 0, outstanding_o goes 1 -> 0.
REQ-029 Both ports request continuously, mem_gnt_i = 1, responses returned in order -> grants D,S,D,S with RR_EN, D,D,D,D without it; every rvalid reaches the issuing port.
REQ-030 NumOutstanding = 2, two grants with no responses -> mem_req_o = 0 and gnts = 0; a response arriving together with a new request -> the request is granted in that same cycle, and again in the next cycle.
REQ-031 Shadow request stalled (mem_gnt_i = 0 for 3 cycles) while data asserts req in cycle 1 -> mem_addr_o holds the shadow address until the grant, then data is served.
REQ-032 mem_rvalid_i pulse with outstanding_o = 0 -> no rvalid_o; unexp_rsp_o = 1 persists; rst_i pulse -> unexp_rsp_o = 0.
REQ-033 rst_i asserted with 2 in flight -> outstanding_o = 0 next cycle; a late mem_rvalid_i sets unexp_rsp_o.
